// File: rtl/quad_encoder_gen.sv
`default_nettype none
// ============================================================================
//  Module   : quad_encoder_gen
//  Purpose  : Quadrature encoder emulator. Emits a commanded number of A/B
//             edges at a programmable rate, with an index pulse (Z) once per
//             revolution of CPR edges, and tracks a 16-bit edge position.
//  Revision : 1.0  initial release
// ============================================================================
module quad_encoder_gen #(
  parameter int CPR = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_steps,
  input  logic        cmd_dir,
  input  logic [15:0] period,
  input  logic        abort,
  output logic        outA,
  output logic        outB,
  output logic        outZ,
  output logic [15:0] position,
  output logic        busy,
  output logic        done
);

  // Width of the within-revolution counter; CPR=4 still needs two bits.
  localparam int              c_RW      = (CPR > 2) ? $clog2(CPR) : 1;
  localparam logic [c_RW-1:0] c_REV_MAX = c_RW'(CPR - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [15:0]     r_pos;
  logic [c_RW-1:0] r_rev_pos;
  logic [15:0]     r_remaining;
  logic [15:0]     r_timer;
  logic [15:0]     r_reload;
  logic            r_dir;
  logic            r_out_a;
  logic            r_out_b;
  logic            r_out_z;
  logic            r_done;

  logic            w_accept;
  logic            w_step;
  logic            w_last;
  logic [15:0]     w_pos_next;
  logic [c_RW-1:0] w_rev_next;
  logic [15:0]     w_reload;

  // Next-state logic and the per-cycle step decode shared with the datapath.
  always_comb begin
    w_state_next = r_state;
    w_accept     = (r_state == S_IDLE) && cmd_valid;
    // Abort masks the step so a coincident final edge is never emitted.
    w_step       = (r_state == S_RUN) && !abort && (r_timer == 16'd0);
    w_last       = w_step && (r_remaining == 16'd1);
    w_pos_next   = r_dir ? (r_pos - 16'd1) : (r_pos + 16'd1);
    if (r_dir) begin
      w_rev_next = (r_rev_pos == '0) ? c_REV_MAX : (r_rev_pos - c_RW'(1));
    end else begin
      w_rev_next = (r_rev_pos == c_REV_MAX) ? '0 : (r_rev_pos + c_RW'(1));
    end
    // A period of 0 behaves as 1: one edge every clock.
    w_reload     = (period == 16'd0) ? 16'd0 : (period - 16'd1);

    case (r_state)
      S_IDLE: begin
        if (w_accept && (cmd_steps != 16'd0)) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (abort || w_last) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Move datapath: command latch, edge timer, position and registered pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos       <= 16'd0;
      r_rev_pos   <= '0;
      r_remaining <= 16'd0;
      r_timer     <= 16'd0;
      r_reload    <= 16'd0;
      r_dir       <= 1'b0;
      r_out_a     <= 1'b0;
      r_out_b     <= 1'b0;
      r_out_z     <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (cmd_steps == 16'd0) begin
          // Empty move: completes immediately without touching the pins.
          r_done <= 1'b1;
        end else begin
          r_remaining <= cmd_steps;
          r_dir       <= cmd_dir;
          r_timer     <= w_reload;
          r_reload    <= w_reload;
        end
      end else if ((r_state == S_RUN) && !abort) begin
        if (r_timer != 16'd0) begin
          r_timer <= r_timer - 16'd1;
        end else begin
          r_pos       <= w_pos_next;
          r_rev_pos   <= w_rev_next;
          // Gray mapping 0->00, 1->10, 2->11, 3->01 (A,B).
          r_out_a     <= w_pos_next[1] ^ w_pos_next[0];
          r_out_b     <= w_pos_next[1];
          r_out_z     <= (w_rev_next == '0);
          r_timer     <= r_reload;
          r_remaining <= r_remaining - 16'd1;
          if (w_last) begin
            r_done <= 1'b1;
          end
        end
      end
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_RUN);
  assign outA      = r_out_a;
  assign outB      = r_out_b;
  assign outZ      = r_out_z;
  assign position  = r_pos;
  assign done      = r_done;

endmodule
`default_nettype wire
